// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Purpose:
//   Bundles the requester-side handshake and the transmitter-side signals of
//   the UART TX arbiter into one interface. The arbiter connects through the
//   'master' modport. The environment (requesters plus the UART transmitter)
//   connects through the 'slave' modport.
//
// Signal summary:
//   req       [N_REQ]           per-requester "byte available" level
//   req_data  [N_REQ*DATA_BIT]  packed bytes, requester i at [i*DATA_BIT +: DATA_BIT]
//   gnt       [N_REQ]           one-hot single-cycle "byte taken" pulse
//   tx_data   [DATA_BIT]        registered byte presented to the transmitter
//   tx_start                    single-cycle start pulse to the transmitter
//   tx_ready                    transmitter idle flag (high = idle)
//   owner     [clog2(N_REQ)]    current or last granted requester
//   busy                        arbiter is not idle
//   err                         sticky start-acknowledge timeout flag
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int DATA_BIT = 8
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_BIT-1:0] req_data;
    logic [N_REQ-1:0]          gnt;
    logic [DATA_BIT-1:0]       tx_data;
    logic                      tx_start;
    logic                      tx_ready;
    logic [OW-1:0]             owner;
    logic                      busy;
    logic                      err;

    // Arbiter side
    modport master (
        input  req, req_data, tx_ready,
        output gnt, tx_data, tx_start, owner, busy, err
    );

    // Requesters and transmitter side
    modport slave (
        output req, req_data, tx_ready,
        input  gnt, tx_data, tx_start, owner, busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Round-robin arbiter that shares a single UART transmitter among N_REQ
//   byte producers. It picks a requester, loads that requester's byte into
//   tx_data and pulses tx_start. It then follows tx_ready through the frame
//   before it arbitrates again.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-low reset
//   bus   uart_tx_arbiter_if.master (req, req_data, tx_ready in;
//         gnt, tx_data, tx_start, owner, busy, err out)
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   DATA_BIT     byte width, must match the transmitter
//   ACK_TIMEOUT  cycles after tx_start within which tx_ready must fall
//   BURST_MAX    maximum consecutive bytes per ownership (burst build only)
//
// Configuration:
//   `define UART_ARB_BURST_EN enables burst continuation. When the owner still
//   requests at the end of a frame, it keeps the transmitter for up to
//   BURST_MAX bytes without re-arbitration. Without the macro, ownership
//   rotates after every byte and no burst counter exists.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_BIT    = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int BURST_MAX   = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    // Reject parameter sets the arbiter is not built for.
    if (N_REQ < 2 || N_REQ > 8 || ACK_TIMEOUT < 1 || BURST_MAX < 1) begin : gBadParam
        $error("uart_tx_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_BIT-1:0] txData_q, txData_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;

`ifdef UART_ARB_BURST_EN
    localparam int BW = $clog2(BURST_MAX + 1);
    logic [BW-1:0]       burst_q, burst_d;
`endif

    // Unpack the flat data bus so each byte can be selected by requester index.
    logic [DATA_BIT-1:0] reqByte [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : gUnpack
        assign reqByte[g] = bus.req_data[g*DATA_BIT +: DATA_BIT];
    end

    // Round-robin search. The search starts one past the last owner and wraps.
    // The last candidate is the owner itself, so a lone request from the
    // previous owner is still served.
    logic          found;
    logic [OW-1:0] winner;
    always_comb begin
        found  = 1'b0;
        winner = owner_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req[OW'((int'(owner_q) + k) % N_REQ)]) begin
                found  = 1'b1;
                winner = OW'((int'(owner_q) + k) % N_REQ);
            end
        end
    end

    // State register and datapath registers. The reset is sampled at the edge,
    // so a reset mid-frame drops straight back to IDLE and LOAD is never
    // entered in that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OW'(N_REQ - 1);
            txData_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
`ifdef UART_ARB_BURST_EN
            burst_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            txData_q <= txData_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef UART_ARB_BURST_EN
            burst_q  <= burst_d;
`endif
        end
    end

    // Next-state logic. LOAD preloads the counter with 1, so cnt_q equals the
    // number of cycles since tx_start while in WAIT_BUSY. The timeout then
    // lands err on cycle LOAD+ACK_TIMEOUT. A timed-out byte still counts as
    // sent, and owner is kept so that rotation advances.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        txData_d = txData_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
`ifdef UART_ARB_BURST_EN
        burst_d  = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_ready && found) begin
                    owner_d  = winner;
                    txData_d = reqByte[winner];
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = CW'(1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
`ifdef UART_ARB_BURST_EN
                    burst_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.tx_ready) begin
`ifdef UART_ARB_BURST_EN
                    // The owner keeps the transmitter while it still has bytes
                    // and its burst allowance is not used up.
                    if (bus.req[owner_q] && (burst_q < BW'(BURST_MAX - 1))) begin
                        burst_d  = burst_q + BW'(1);
                        txData_d = reqByte[owner_q];
                        state_d  = LOAD;
                    end else begin
                        burst_d  = '0;
                        state_d  = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. tx_start and gnt are decoded from LOAD, so each one is exactly
    // one cycle wide.
    always_comb begin
        bus.tx_start = (state_q == LOAD);
        bus.gnt      = (state_q == LOAD) ? (N_REQ'(1) << owner_q) : '0;
        bus.tx_data  = txData_q;
        bus.owner    = owner_q;
        bus.busy     = (state_q != IDLE);
        bus.err      = err_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_BIT=8,
// ACK_TIMEOUT=4, BURST_MAX=3). A behavioural transmitter drops tx_ready for
// FRAME cycles after each tx_start. It can be told never to acknowledge, which
// exercises the timeout. Expected grants are queued when requests are driven.
// A negedge monitor pops and compares them whenever the arbiter pulses
// tx_start or gnt.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N_REQ       = 4;
    localparam int DATA_BIT    = 8;
    localparam int ACK_TIMEOUT = 4;
    localparam int BURST_MAX   = 3;
    localparam int FRAME       = 20;

    logic clk;
    logic rst;
    logic txNoAck;
    logic txReady;
    int   frameCnt;
    int   cycleCnt;
    int   checkCount;
    int   errCount;
    logic [3:0] prevGnt;
    logic sawGnt1;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic [1:0] owner;
        int         cyc;
    } exp_t;

    exp_t sbQ[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  expGnt;
        logic [1:0]  expOwner;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[9];

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_BIT(DATA_BIT)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .DATA_BIT(DATA_BIT),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock and a free-running cycle counter used to check grant latency.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Transmitter model: a start drops tx_ready on the next cycle for FRAME cycles.
    always @(posedge clk) begin
        if (!rst) begin
            txReady  <= 1'b1;
            frameCnt <= 0;
        end else if (bus.tx_start && !txNoAck) begin
            txReady  <= 1'b0;
            frameCnt <= FRAME;
        end else if (frameCnt > 0) begin
            frameCnt <= frameCnt - 1;
            if (frameCnt == 1) txReady <= 1'b1;
        end
    end

    assign bus.tx_ready = txReady;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycleCnt);
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (prevGnt != 4'b0)
                checkOutput("gntPulseWidth", {28'b0, bus.gnt}, 32'h0);
            if (bus.tx_start || bus.gnt != 4'b0) begin
                if (bus.gnt[1]) sawGnt1 = 1'b1;
                if (sbQ.size() == 0) begin
                    checkOutput("spuriousGrant", {27'b0, bus.tx_start, bus.gnt}, 32'h0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("gnt",      {28'b0, bus.gnt},   {28'b0, e.gnt});
                    checkOutput("txStart",  {31'b0, bus.tx_start}, 32'h1);
                    checkOutput("txData",   {24'b0, bus.tx_data}, {24'b0, e.data});
                    checkOutput("owner",    {30'b0, bus.owner}, {30'b0, e.owner});
                    if (e.cyc >= 0)
                        checkOutput("grantLatency", cycleCnt, e.cyc);
                end
            end
        end
        prevGnt = bus.gnt;
    end

    task automatic applyStimulus(input logic [3:0] reqV, input logic [31:0] dataV);
        bus.req      = reqV;
        bus.req_data = dataV;
    endtask

    task automatic pushExp(input logic [3:0] g, input logic [7:0] d,
                           input logic [1:0] o, input int cyc);
        exp_t e;
        e.gnt   = g;
        e.data  = d;
        e.owner = o;
        e.cyc   = cyc;
        sbQ.push_back(e);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitForStart(input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (bus.tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("startTimeout", 32'h0, 32'h1);
    endtask

    task automatic waitIdle(input int maxCycles);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) checkOutput("idleTimeout", 32'h0, 32'h1);
    endtask

    task automatic waitQueueEmpty(input int maxCycles);
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            if (sbQ.size() == 0) begin
                empty = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!empty) checkOutput("scoreboardTimeout", sbQ.size(), 32'h0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        errCount   = 0;
        cycleCnt   = 0;
        prevGnt    = 4'b0;
        sawGnt1    = 1'b0;
        txNoAck    = 1'b0;
        rst        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;

        // Single-request vectors. Expected winners follow the rotation from owner=3.
        vecs[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5};
        vecs[1] = '{4'b0001, 32'h0000_003C, 4'b0001, 2'd0, 8'h3C};
        vecs[2] = '{4'b1010, 32'h8100_7E00, 4'b0010, 2'd1, 8'h7E};
        vecs[3] = '{4'b1010, 32'h8100_7E00, 4'b1000, 2'd3, 8'h81};
        vecs[4] = '{4'b1001, 32'h9900_0011, 4'b0001, 2'd0, 8'h11};
        vecs[5] = '{4'b0110, 32'h0044_2200, 4'b0010, 2'd1, 8'h22};
        vecs[6] = '{4'b1111, 32'hDDCC_BBAA, 4'b0100, 2'd2, 8'hCC};
        vecs[7] = '{4'b1011, 32'hDDCC_BBAA, 4'b1000, 2'd3, 8'hDD};
        vecs[8] = '{4'b0011, 32'hDDCC_BBAA, 4'b0001, 2'd0, 8'hAA};

        applyReset();
        checkOutput("rstTxStart", {31'b0, bus.tx_start}, 32'h0);
        checkOutput("rstGnt",     {28'b0, bus.gnt},      32'h0);
        checkOutput("rstTxData",  {24'b0, bus.tx_data},  32'h0);
        checkOutput("rstBusy",    {31'b0, bus.busy},     32'h0);
        checkOutput("rstErr",     {31'b0, bus.err},      32'h0);
        checkOutput("rstOwner",   {30'b0, bus.owner},    32'h3);

        // Table: the grant must appear exactly one cycle after the request is seen.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].data);
            pushExp(vecs[i].expGnt, vecs[i].expData, vecs[i].expOwner, cycleCnt + 1);
            waitForStart(10);
            applyStimulus(4'b0000, vecs[i].data);
            waitIdle(100);
        end
        checkOutput("tableErrClear", {31'b0, bus.err}, 32'h0);

        // Contention: all four requesters held.
        applyReset();
        applyStimulus(4'b1111, 32'h1312_1110);
`ifdef UART_ARB_BURST_EN
        pushExp(4'b0001, 8'h10, 2'd0, -1);
        pushExp(4'b0001, 8'h10, 2'd0, -1);
        pushExp(4'b0001, 8'h10, 2'd0, -1);
        pushExp(4'b0010, 8'h11, 2'd1, -1);
        pushExp(4'b0010, 8'h11, 2'd1, -1);
`else
        pushExp(4'b0001, 8'h10, 2'd0, -1);
        pushExp(4'b0010, 8'h11, 2'd1, -1);
        pushExp(4'b0100, 8'h12, 2'd2, -1);
        pushExp(4'b1000, 8'h13, 2'd3, -1);
        pushExp(4'b0001, 8'h10, 2'd0, -1);
`endif
        waitQueueEmpty(400);
        applyStimulus(4'b0000, 32'h0);
        waitIdle(100);

        // Two requesters held: rotation without burst, grouped grants with burst.
        applyReset();
        applyStimulus(4'b0011, 32'h0000_B2A1);
`ifdef UART_ARB_BURST_EN
        pushExp(4'b0001, 8'hA1, 2'd0, -1);
        pushExp(4'b0001, 8'hA1, 2'd0, -1);
        pushExp(4'b0001, 8'hA1, 2'd0, -1);
        pushExp(4'b0010, 8'hB2, 2'd1, -1);
        pushExp(4'b0010, 8'hB2, 2'd1, -1);
        pushExp(4'b0010, 8'hB2, 2'd1, -1);
`else
        pushExp(4'b0001, 8'hA1, 2'd0, -1);
        pushExp(4'b0010, 8'hB2, 2'd1, -1);
        pushExp(4'b0001, 8'hA1, 2'd0, -1);
        pushExp(4'b0010, 8'hB2, 2'd1, -1);
`endif
        waitQueueEmpty(400);
        applyStimulus(4'b0000, 32'h0);
        waitIdle(100);

        // Timeout: the transmitter never acknowledges the start.
        applyReset();
        txNoAck = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0055);
        pushExp(4'b0001, 8'h55, 2'd0, cycleCnt + 1);
        waitForStart(10);
        applyStimulus(4'b0000, 32'h0);
        repeat (ACK_TIMEOUT - 1) @(negedge clk);
        checkOutput("errBeforeTimeout",  {31'b0, bus.err},  32'h0);
        checkOutput("busyBeforeTimeout", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        checkOutput("errAtTimeout",  {31'b0, bus.err},  32'h1);
        checkOutput("busyAtTimeout", {31'b0, bus.busy}, 32'h0);
        applyStimulus(4'b0010, 32'h0000_6600);
        pushExp(4'b0010, 8'h66, 2'd1, cycleCnt + 1);
        waitForStart(10);
        applyStimulus(4'b0000, 32'h0);
        waitIdle(20);
        checkOutput("errSticky", {31'b0, bus.err}, 32'h1);

        // Reset in the middle of a frame (WAIT_DONE), with err already set.
        txNoAck = 1'b0;
        applyStimulus(4'b0100, 32'h00A5_0000);
        pushExp(4'b0100, 8'hA5, 2'd2, cycleCnt + 1);
        waitForStart(10);
        applyStimulus(4'b0000, 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("midFrameBusy", {31'b0, bus.busy}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy",    {31'b0, bus.busy},     32'h0);
        checkOutput("midRstOwner",   {30'b0, bus.owner},    32'h3);
        checkOutput("midRstErr",     {31'b0, bus.err},      32'h0);
        checkOutput("midRstTxStart", {31'b0, bus.tx_start}, 32'h0);
        checkOutput("midRstGnt",     {28'b0, bus.gnt},      32'h0);
        rst = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0077);
        pushExp(4'b0001, 8'h77, 2'd0, cycleCnt + 1);
        waitForStart(10);
        applyStimulus(4'b0000, 32'h0);
        waitIdle(100);

        // Withdrawn request: req[1] pulses for one cycle while busy.
        sawGnt1 = 1'b0;
        applyStimulus(4'b0001, 32'h0000_0088);
        pushExp(4'b0001, 8'h88, 2'd0, cycleCnt + 1);
        waitForStart(10);
        applyStimulus(4'b0000, 32'h0);
        repeat (3) @(negedge clk);
        applyStimulus(4'b0010, 32'h0000_9900);
        @(negedge clk);
        applyStimulus(4'b0000, 32'h0);
        waitIdle(100);
        repeat (5) @(negedge clk);
        checkOutput("withdrawnNoGnt1", {31'b0, sawGnt1}, 32'h0);
        checkOutput("scoreboardDrained", sbQ.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin arbiter that shares one UART transmitter among `N_REQ` byte producers.
- It selects a requester, loads its byte into the transmitter and pulses the transmitter's start input. It then tracks the transmitter's ready line until the frame is done.
- It sits between application sources (status reporter, echo path, debug dump) and the single UART TX on the board pin.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_BIT`, 8: byte width; must match the transmitter.
- `ACK_TIMEOUT`, 4: cycles allowed for `tx_ready` to fall after `tx_start`.
- `BURST_MAX`, 4: maximum consecutive bytes per ownership. Used only with `UART_ARB_BURST_EN`.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset. Synchronous and active-low.
- `req`, in, `N_REQ`: per-requester "byte available" level.
- `req_data`, in, `N_REQ*DATA_BIT`: packed bytes. Requester i occupies `[i*DATA_BIT +: DATA_BIT]`.
- `gnt`, out, `N_REQ`: one-hot, one-cycle pulse. Means "your byte was taken".
- `tx_data`, out, `DATA_BIT`: registered byte to the transmitter.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_ready`, in, 1: transmitter idle flag. High = idle.
- `owner`, out, `$clog2(N_REQ)`: index of the current or last granted requester.
- `busy`, out, 1: high in every state except IDLE.
- `err`, out, 1: sticky timeout flag.

## Operation
States are IDLE, LOAD, WAIT_BUSY and WAIT_DONE.

- IDLE
  - When `tx_ready`=1 and any `req` bit is high, select a winner combinationally.
  - The search starts at `owner+1` and wraps modulo `N_REQ`. The first set bit wins.
  - Register the winner into `owner`. Capture its byte into `tx_data`. Go to LOAD.
  - If `tx_ready`=0 or `req`=0, stay in IDLE.
- LOAD
  - Lasts exactly one cycle.
  - `tx_start`=1, and `gnt[owner]`=1 for this cycle only. Go to WAIT_BUSY.
- WAIT_BUSY
  - Count cycles. When `tx_ready`=0, clear the count and go to WAIT_DONE.
  - If the count reaches `ACK_TIMEOUT` with `tx_ready` still high, set `err`=1 and go to IDLE. The byte counts as consumed; `owner` keeps its value, so rotation still advances.
- WAIT_DONE
  - When `tx_ready`=1, go to IDLE. Burst continuation is described under Configuration.

Rules:
- `req_data` for requester i must be stable from `req[i]` rising until `gnt[i]`.
- A requester may present its next byte in the cycle after `gnt`.
- If `req[i]` drops before grant, it is simply not selected. There is no error.
- Requests that arrive while `busy`=1 wait. Nothing is lost, because `req` is a level.
- `err` clears only on reset.

Reset values (`rst`=0 at a clock edge):
- Outputs: `tx_start`=0, `gnt`=0, `tx_data`=0, `busy`=0, `err`=0.
- `owner`=`N_REQ-1`, so requester 0 has first priority.
- Internal: state = IDLE, all counters 0.
- Reset in any state, including mid-frame, takes effect at that edge. No `gnt` or `tx_start` is issued in that cycle.

## Timing
- Latency: `req` seen in IDLE at edge t → `tx_start`/`gnt` high during cycle t+1 (LOAD).
- `tx_data` is valid from t+1 and is held until the next LOAD.
- Gap between grants for back-to-back bytes: one frame plus 2 cycles (WAIT_DONE→IDLE→LOAD).
- Simultaneous requests are served one per frame in round-robin order. No requester waits more than `N_REQ-1` frames (without burst).
- `tx_ready` falling in the same cycle as LOAD is ignored. It is only evaluated from WAIT_BUSY onward.

## Configuration
Macro: `UART_ARB_BURST_EN`.

- Defined:
  - In WAIT_DONE with `tx_ready`=1, if `req[owner]`=1 and the burst count < `BURST_MAX-1`, increment the burst count.
  - Capture `req_data[owner]` and go directly to LOAD, with no arbitration.
  - Otherwise go to IDLE and clear the burst count.
  - Burst continuation takes 1 cycle from `tx_ready`=1 to LOAD.
- Not defined:
  - WAIT_DONE always returns to IDLE, so ownership rotates after every byte.
  - No burst counter is built.
  - `BURST_MAX` is ignored.

## Test plan
- Single request: `req`=4'b0100, `req_data` byte2=8'hA5 → `gnt`=4'b0100 and `tx_start` one cycle after, `tx_data`=8'hA5, `owner`=2.
- Contention: `req`=4'b1111 held, transmitter model 20-cycle frames → grant order 0,1,2,3,0, each `gnt` a single-cycle pulse.
- Burst (`UART_ARB_BURST_EN`, `BURST_MAX`=3): `req`=4'b0011 held → grants 0,0,0,1,1,1. Without the macro → 0,1,0,1.
- Timeout: transmitter model never drops `tx_ready` → `err`=1 on cycle LOAD+`ACK_TIMEOUT`, state IDLE, the next request is still granted.
- Reset mid-frame: `rst`=0 during WAIT_DONE → next cycle `busy`=0, `owner`=3, `err`=0. After release, `req`=4'b0001 is granted to 0.
- Withdrawn request: `req[1]` pulses for 1 cycle while `busy`=1 → no `gnt[1]` issued.
